// File: rtl/cv32e40p_div_pkg.sv
// Shared types and width constants for the serial-divider issue controller
// and its helpers.
package cv32e40p_div_pkg;

  localparam int unsigned DivWidth    = 32;
  localparam int unsigned DivLogWidth = 6;

  typedef enum logic [1:0] {
    DIV_UDIV = 2'd0,
    DIV_DIV  = 2'd1,
    DIV_UREM = 2'd2,
    DIV_REM  = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StDrain
  } div_state_e;

endpackage

// File: rtl/cv32e40p_div_issue_ctrl_if.sv
// Request/response handshake plus the divider-facing bus of the issue controller.
interface cv32e40p_div_issue_ctrl_if #(
  parameter int unsigned Width    = 32,
  parameter int unsigned LogWidth = 6
);
  import cv32e40p_div_pkg::*;

  logic                req_vld;
  logic                req_rdy;
  div_op_e             req_op;
  logic [Width-1:0]    req_a;
  logic [Width-1:0]    req_b;
  logic                flush;
  logic                rsp_vld;
  logic                rsp_rdy;
  logic [Width-1:0]    rsp_res;
  logic                busy;
  logic [Width-1:0]    div_op_a;
  logic [Width-1:0]    div_op_b;
  logic [LogWidth-1:0] div_op_b_shift;
  logic                div_op_b_is_zero;
  logic                div_op_b_sign;
  div_op_e             div_op_code;
  logic                div_in_vld;
  logic                div_out_rdy;
  logic                div_out_vld;
  logic [Width-1:0]    div_res;

  // Controller view.
  modport slave (
    input  req_vld, req_op, req_a, req_b, flush, rsp_rdy, div_out_vld, div_res,
    output req_rdy, rsp_vld, rsp_res, busy, div_op_a, div_op_b, div_op_b_shift,
           div_op_b_is_zero, div_op_b_sign, div_op_code, div_in_vld, div_out_rdy
  );

  // Requester and divider view.
  modport master (
    output req_vld, req_op, req_a, req_b, flush, rsp_rdy, div_out_vld, div_res,
    input  req_rdy, rsp_vld, rsp_res, busy, div_op_a, div_op_b, div_op_b_shift,
           div_op_b_is_zero, div_op_b_sign, div_op_code, div_in_vld, div_out_rdy
  );

endinterface

// File: rtl/cv32e40p_div_lzc.sv
// Combinational leading-zero counter; cnt equals C_WIDTH when the input is all zero.
module cv32e40p_div_lzc #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     in_data,
  output logic [C_LOG_WIDTH-1:0] cnt,
  output logic                   all_zero
);

  // Scan upward so the most significant set bit wins.
  always_comb begin
    cnt = C_LOG_WIDTH'(C_WIDTH);
    for (int unsigned i = 0; i < C_WIDTH; i++) begin
      if (in_data[i]) cnt = C_LOG_WIDTH'(C_WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|in_data;

endmodule

// File: rtl/cv32e40p_div_issue_ctrl.sv
// Requester-side controller for the serial divider: registers a request, issues
// a one-cycle InVld, collects the result and supports flushing an in-flight op.
module cv32e40p_div_issue_ctrl
  import cv32e40p_div_pkg::*;
#(
  parameter int unsigned C_WIDTH     = DivWidth,
  parameter int unsigned C_LOG_WIDTH = DivLogWidth
) (
  input logic                      clk,
  input logic                      rst_n,
  cv32e40p_div_issue_ctrl_if.slave bus
);

  div_state_e             state_q, state_d;
  logic [C_WIDTH-1:0]     op_a_q, op_b_q, res_q;
  logic [C_LOG_WIDTH-1:0] shift_q;
  logic                   is_zero_q, sign_q;
  div_op_e                op_q;

  logic                   req_rdy, in_vld, out_rdy, rsp_vld, capture, req_hs;
  logic                   op_signed, b_sign, b_scan_zero;
  logic [C_WIDTH-1:0]     b_scan;
  logic [C_LOG_WIDTH-1:0] lz_cnt, lz, shift_d;

  // Side-band is computed from the raw request and only reaches the divider via registers.
  assign op_signed = bus.req_op[0];
  assign b_sign    = op_signed & bus.req_b[C_WIDTH-1];
  assign b_scan    = b_sign ? ~bus.req_b : bus.req_b;

  cv32e40p_div_lzc #(
    .C_WIDTH    (C_WIDTH),
    .C_LOG_WIDTH(C_LOG_WIDTH)
  ) u_lzc (
    .in_data (b_scan),
    .cnt     (lz_cnt),
    .all_zero(b_scan_zero)
  );

  assign lz      = b_scan_zero ? C_LOG_WIDTH'(C_WIDTH - 1) : lz_cnt;
  assign shift_d = lz + (op_signed ? '0 : C_LOG_WIDTH'(1));
  assign req_hs  = bus.req_vld & req_rdy;

  always_comb begin
    state_d = state_q;
    req_rdy = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    rsp_vld = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        req_rdy = ~bus.flush;
        if (bus.req_vld && !bus.flush) state_d = StIssue;
      end
      StIssue: begin
        in_vld  = 1'b1;
        state_d = bus.flush ? StDrain : StWait;
      end
      StWait: begin
        out_rdy = 1'b1;
        if (bus.div_out_vld) begin
          capture = ~bus.flush;
          state_d = bus.flush ? StIdle : StResp;
        end else if (bus.flush) begin
          state_d = StDrain;
        end
      end
      StResp: begin
        rsp_vld = 1'b1;
        if (bus.flush || bus.rsp_rdy) state_d = StIdle;
      end
      StDrain: begin
        // The divider cannot be aborted; swallow its stale result.
        out_rdy = 1'b1;
        if (bus.div_out_vld) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_q      <= DIV_UDIV;
      shift_q   <= '0;
      is_zero_q <= 1'b0;
      sign_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        op_a_q    <= bus.req_a;
        op_b_q    <= bus.req_b;
        op_q      <= bus.req_op;
        shift_q   <= shift_d;
        is_zero_q <= (bus.req_b == '0);
        sign_q    <= b_sign;
      end
      if (capture) res_q <= bus.div_res;
    end
  end

  assign bus.req_rdy          = req_rdy;
  assign bus.rsp_vld          = rsp_vld;
  assign bus.rsp_res          = res_q;
  assign bus.busy             = (state_q != StIdle);
  assign bus.div_op_a         = op_a_q;
  assign bus.div_op_b         = op_b_q;
  assign bus.div_op_b_shift   = shift_q;
  assign bus.div_op_b_is_zero = is_zero_q;
  assign bus.div_op_b_sign    = sign_q;
  assign bus.div_op_code      = op_q;
  assign bus.div_in_vld       = in_vld;
  assign bus.div_out_rdy      = out_rdy;

endmodule

// File: tb/tb_cv32e40p_div_issue_ctrl.sv
// Randomized scoreboard bench for the divider issue controller with a
// behavioural divider model and RISC-V division reference.
module tb_cv32e40p_div_issue_ctrl;
  import cv32e40p_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cv32e40p_div_issue_ctrl_if #(.Width(DivWidth), .LogWidth(DivLogWidth)) bus ();

  cv32e40p_div_issue_ctrl #(
    .C_WIDTH    (DivWidth),
    .C_LOG_WIDTH(DivLogWidth)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } req_t;

  req_t        issue_q[$];
  logic [31:0] rsp_q[$];
  int unsigned n_pass = 0, n_total = 0;
  int unsigned acc_cnt = 0, rsp_cnt = 0, drop_cnt = 0;
  logic        dm_busy = 1'b0;
  bit          aborted = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // RISC-V M-extension division semantics.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0:    ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    ref_result = (b == 0) ? a : a % b;
      2'd1: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = a;
        else ref_result = $unsigned(sa / sb);
      end
      default: begin
        if (b == 0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
        else ref_result = $unsigned(sa % sb);
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] bs;
    int          lz;
    bs = (op[0] && b[31]) ? ~b : b;
    lz = 0;
    while (lz < 32 && bs[31-lz] == 1'b0) lz++;
    if (lz == 32) lz = 31;
    if (!op[0]) lz++;
    return 32'(lz % 64);
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom() >> $urandom_range(0, 31);
      default: return $urandom();
    endcase
  endfunction

  // Divider model: sample at negedge, update just after posedge.
  initial begin : divider
    logic [31:0] la, lb, nres;
    logic [1:0]  lop;
    logic        nb, nv;
    int          lat;
    req_t        e;
    la = 0; lb = 0; lop = 0; lat = 0;
    bus.div_out_vld = 1'b0;
    bus.div_res     = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dm_busy         = 1'b0;
        bus.div_out_vld = 1'b0;
      end else begin
        nb   = dm_busy;
        nv   = bus.div_out_vld;
        nres = bus.div_res;
        if (bus.div_in_vld) begin
          check("in_vld_while_busy", 32'(dm_busy), 32'd0);
          if (issue_q.size() == 0) begin
            check("in_vld_unexpected", 32'(issue_q.size()), 32'd1);
          end else begin
            e = issue_q.pop_front();
            check("div_op_a", bus.div_op_a, e.a);
            check("div_op_b", bus.div_op_b, e.b);
            check("div_op_code", 32'(bus.div_op_code), 32'(e.op));
            check("div_shift", 32'(bus.div_op_b_shift), ref_shift(e.op, e.b));
            check("div_is_zero", 32'(bus.div_op_b_is_zero), 32'(e.b == 0));
            check("div_sign", 32'(bus.div_op_b_sign), 32'(e.op[0] & e.b[31]));
          end
          la  = bus.div_op_a;
          lb  = bus.div_op_b;
          lop = bus.div_op_code;
          nb  = 1'b1;
          lat = $urandom_range(1, 6);
        end else if (dm_busy && !bus.div_out_vld) begin
          if (lat == 0) begin
            nv   = 1'b1;
            nres = ref_result(lop, la, lb);
          end else begin
            lat--;
          end
        end else if (bus.div_out_vld && bus.div_out_rdy) begin
          check("hold_op_a", bus.div_op_a, la);
          check("hold_op_b", bus.div_op_b, lb);
          check("hold_op_code", 32'(bus.div_op_code), 32'(lop));
          nv = 1'b0;
          nb = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
          dm_busy         = nb;
          bus.div_out_vld = nv;
          bus.div_res     = nres;
        end
      end
    end
  end

  initial begin : rsp_ready_gen
    bus.rsp_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_rdy = ($urandom_range(0, 1) == 1);
    end
  end

  // Response monitor and handshake-level protocol checks.
  initial begin : monitor
    logic        hold, outstanding, quiet;
    logic [31:0] hold_res;
    hold = 1'b0;
    hold_res = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("rsp_vld_held", 32'(bus.rsp_vld), 32'd1);
          check("rsp_res_stable", bus.rsp_res, hold_res);
        end
        hold        = 1'b0;
        outstanding = (acc_cnt > rsp_cnt + drop_cnt);
        quiet       = !dm_busy && (issue_q.size() == 0);
        if (bus.flush) begin
          check("req_rdy_flush", 32'(bus.req_rdy), 32'd0);
        end else begin
          check("req_rdy", 32'(bus.req_rdy), 32'(quiet && !outstanding));
          check("rsp_vld", 32'(bus.rsp_vld), 32'(quiet && outstanding));
        end
        if (bus.rsp_vld && bus.rsp_rdy && !bus.flush) begin
          if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_q.size()), 32'd1);
          else check("rsp_res", bus.rsp_res, rsp_q.pop_front());
          rsp_cnt++;
        end else if (bus.rsp_vld && !bus.flush) begin
          hold     = 1'b1;
          hold_res = bus.rsp_res;
        end
      end
    end
  end

  // Called just after a posedge; returns just after a posedge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at);
    int t;
    if (aborted) return;
    bus.req_op  = div_op_e'(op);
    bus.req_a   = a;
    bus.req_b   = b;
    bus.req_vld = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.req_rdy) break;
      t++;
      if (t > 200) begin
        n_total++;
        $display("FAIL accept_timeout: req_rdy stayed 0 for %0d cycles, required 1", t);
        aborted     = 1'b1;
        bus.req_vld = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.req_vld = 1'b0;
    bus.req_a   = $urandom();
    bus.req_b   = $urandom();
    issue_q.push_back('{a: a, b: b, op: op});
    rsp_q.push_back(ref_result(op, a, b));
    acc_cnt++;
    if (flush_at >= 0) begin
      repeat (flush_at) begin
        @(posedge clk);
        #1;
      end
      bus.flush = 1'b1;
      if (acc_cnt > rsp_cnt + drop_cnt) begin
        void'(rsp_q.pop_back());
        drop_cnt++;
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!aborted && (acc_cnt > rsp_cnt + drop_cnt || dm_busy || issue_q.size() != 0)) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 500) begin
        n_total++;
        $display("FAIL idle_timeout: outstanding ops after %0d cycles, required 0", t);
        aborted = 1'b1;
      end
    end
  endtask

  initial begin : main
    logic [1:0] op;
    int         fa, t;
    bus.req_vld = 1'b0;
    bus.req_op  = DIV_UDIV;
    bus.req_a   = 32'd0;
    bus.req_b   = 32'd0;
    bus.flush   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("rst_in_vld", 32'(bus.div_in_vld), 32'd0);
    check("rst_out_rdy", 32'(bus.div_out_rdy), 32'd0);
    check("rst_op_a", bus.div_op_a, 32'd0);
    check("rst_op_b", bus.div_op_b, 32'd0);
    check("rst_shift", 32'(bus.div_op_b_shift), 32'd0);
    check("rst_sideband", {30'd0, bus.div_op_b_is_zero, bus.div_op_b_sign}, 32'd0);
    check("rst_rsp_res", bus.rsp_res, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(2'd0, 32'd100, 32'd7, -1);
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(2'd0, 32'd5, 32'd0, -1);
    do_op(2'd2, 32'd5, 32'd0, -1);
    do_op(2'd0, 32'd1000, 32'd3, 2);   // flush while the divider is still working
    do_op(2'd1, 32'hFFFF_FF00, 32'd9, -1);
    do_op(2'd3, 32'd12345, 32'd10, 0); // flush during the issue cycle
    do_op(2'd2, 32'd12345, 32'd10, -1);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      do_op(op, pick_val(), pick_val(), fa);
    end
    wait_idle();
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    // Asynchronous reset in the middle of an operation.
    do_op(2'd0, 32'd4321, 32'd5, -1);
    t = 0;
    while (!aborted && !dm_busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_out_rdy", 32'(bus.div_out_rdy), 32'd0);
    check("midrst_op_a", bus.div_op_a, 32'd0);
    issue_q.delete();
    rsp_q.delete();
    drop_cnt = acc_cnt - rsp_cnt;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(2'd1, 32'hFFFF_FF9C, 32'd7, -1);
    wait_idle();
    check("final_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
